// File: rtl/m_memcode_server_pkg.sv
// Shared definitions for the memory-code server and its PRN-side clients.
// Holds the code-side FSM state encoding and the default address/data widths
// shared with m_prn_memcode.
package m_memcode_server_pkg;

   localparam int MC_ADDR_WIDTH   = 14;
   localparam int MC_DATA_WIDTH   = 32;
   localparam int MC_STARVE_LIMIT = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } mc_state_e;

endpackage

// File: rtl/m_memcode_server_if.sv
// Bus bundle for m_memcode_server.
//  code side : memcode_rd/memcode_addr in, memcode_read_valid/memcode_data out
//  host side : host_cs/host_wr/host_addr/host_d4wr in,
//              host_ready/host_rd_valid/host_d4rd out
//  SRAM side : mem_cs/mem_we/mem_addr/mem_wdata out, mem_rdata in
// Modport slave is the server view; modport master is the view of the
// surrounding system (code fetcher, host and SRAM together).
interface m_memcode_server_if
   import m_memcode_server_pkg::*;
#(
   parameter int ADDR_WIDTH = MC_ADDR_WIDTH,
   parameter int DATA_WIDTH = MC_DATA_WIDTH
);
   logic                  memcode_rd;
   logic [ADDR_WIDTH-1:0] memcode_addr;
   logic                  memcode_read_valid;
   logic [DATA_WIDTH-1:0] memcode_data;

   logic                  host_cs;
   logic                  host_wr;
   logic [ADDR_WIDTH-1:0] host_addr;
   logic [DATA_WIDTH-1:0] host_d4wr;
   logic                  host_ready;
   logic                  host_rd_valid;
   logic [DATA_WIDTH-1:0] host_d4rd;

   logic                  mem_cs;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  memcode_rd, memcode_addr, host_cs, host_wr, host_addr, host_d4wr, mem_rdata,
      output memcode_read_valid, memcode_data, host_ready, host_rd_valid, host_d4rd,
             mem_cs, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output memcode_rd, memcode_addr, host_cs, host_wr, host_addr, host_d4wr, mem_rdata,
      input  memcode_read_valid, memcode_data, host_ready, host_rd_valid, host_d4rd,
             mem_cs, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/m_memcode_arbiter.sv
// Host / code-fetch arbiter for the shared code SRAM.
//  clk, rst_b    : clock, asynchronous active-low reset
//  code_rd_i     : raw memcode_rd level (clears the starvation count when low)
//  code_req_i    : code fetch wants the SRAM this cycle (IDLE, not a cache hit)
//  code_hit_i    : code fetch served from the cache this cycle
//  host_req_i    : host access request
//  code_grant_o  : code fetch owns the SRAM this cycle
//  host_grant_o  : host access accepted this cycle
// Host normally wins; after STARVE_LIMIT lost cycles the pending fetch is forced.
module m_memcode_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_b,
   input  logic code_rd_i,
   input  logic code_req_i,
   input  logic code_hit_i,
   input  logic host_req_i,
   output logic code_grant_o,
   output logic host_grant_o
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] starve_cnt_q, starve_cnt_d;
   logic          forced;

   assign forced       = (starve_cnt_q == CW'(STARVE_LIMIT));
   assign code_grant_o = code_req_i && (!host_req_i || forced);
   assign host_grant_o = host_req_i && !(code_req_i && forced);

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!code_rd_i || code_grant_o || code_hit_i) begin
         starve_cnt_d = '0;
      end else if (code_req_i && host_grant_o) begin
         // host_grant with a code request implies the count is below the limit
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/m_memcode_server.sv
// Memory-code server: responder for PRN-generator code fetches, fronting one
// single-port SRAM that the host also uses to load and read back code words.
//  clk    : system clock
//  rst_b  : asynchronous active-low reset
//  bus    : m_memcode_server_if.slave (code, host and SRAM signal groups)
// Code fetch: IDLE -> WAIT -> RESP, valid pulses in RESP, 2 cycles after issue.
// Host read data appears the cycle after acceptance; writes take one cycle.
// Optional feature macro: MEMCODE_CACHE_EN adds a one-entry fetch buffer that
// answers a repeated address in 1 cycle without touching the SRAM.
module m_memcode_server
   import m_memcode_server_pkg::*;
#(
   parameter int ADDR_WIDTH   = MC_ADDR_WIDTH,
   parameter int DATA_WIDTH   = MC_DATA_WIDTH,
   parameter int STARVE_LIMIT = MC_STARVE_LIMIT
) (
   input logic                clk,
   input logic                rst_b,
   m_memcode_server_if.slave  bus
);

   mc_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] memcode_data_q, memcode_data_d;
   logic                  host_rd_valid_q;
   logic [DATA_WIDTH-1:0] host_d4rd_q;

   logic                  idle;
   logic                  code_req;
   logic                  code_hit;
   logic [DATA_WIDTH-1:0] hit_data;
   logic                  code_grant;
   logic                  host_grant;
   logic                  host_wr_acc;

   assign idle = (state_q == ST_IDLE);
   // gating with rst_b keeps the SRAM quiet while reset is held
   assign code_req    = rst_b && idle && bus.memcode_rd && !code_hit;
   assign host_wr_acc = host_grant && bus.host_wr;

   m_memcode_arbiter #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_arb (
      .clk          (clk),
      .rst_b        (rst_b),
      .code_rd_i    (bus.memcode_rd),
      .code_req_i   (code_req),
      .code_hit_i   (code_hit),
      .host_req_i   (rst_b && bus.host_cs),
      .code_grant_o (code_grant),
      .host_grant_o (host_grant)
   );

`ifdef MEMCODE_CACHE_EN
   logic [ADDR_WIDTH-1:0] cache_addr_q;
   logic [ADDR_WIDTH-1:0] req_addr_q;
   logic [DATA_WIDTH-1:0] cache_data_q;
   logic                  cache_vld_q;
   logic                  stale_q;
   logic                  host_wr_cache;
   logic                  host_wr_req;

   assign host_wr_cache = host_wr_acc && (bus.host_addr == cache_addr_q);
   assign host_wr_req   = host_wr_acc && (bus.host_addr == req_addr_q);
   // Hit suppression uses the raw host write request, not the grant, since the
   // grant itself depends on whether this cycle is a hit.
   assign code_hit = rst_b && idle && bus.memcode_rd && cache_vld_q &&
                     (bus.memcode_addr == cache_addr_q) &&
                     !(bus.host_cs && bus.host_wr && (bus.host_addr == cache_addr_q));
   assign hit_data = cache_data_q;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cache_addr_q <= '0;
         req_addr_q   <= '0;
         cache_data_q <= '0;
         cache_vld_q  <= 1'b0;
         stale_q      <= 1'b0;
      end else begin
         if (idle && (code_grant || code_hit)) begin
            req_addr_q <= bus.memcode_addr;
         end
         // A host write to the in-flight address after the SRAM read means the
         // word being returned is already old; it must not be cached.
         if (idle) begin
            stale_q <= 1'b0;
         end else if (host_wr_req) begin
            stale_q <= 1'b1;
         end
         if (state_q == ST_RESP) begin
            cache_addr_q <= req_addr_q;
            cache_data_q <= memcode_data_q;
            cache_vld_q  <= !stale_q && !host_wr_req;
         end else if (host_wr_cache) begin
            cache_vld_q <= 1'b0;
         end
      end
   end
`else
   assign code_hit = 1'b0;
   assign hit_data = '0;
`endif

   always_comb begin
      state_d        = state_q;
      memcode_data_d = memcode_data_q;
      case (state_q)
         ST_IDLE: begin
            if (code_grant) begin
               state_d = ST_WAIT;
            end else if (code_hit) begin
               state_d        = ST_RESP;
               memcode_data_d = hit_data;
            end
         end
         ST_WAIT: begin
            memcode_data_d = bus.mem_rdata;
            state_d        = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q         <= ST_IDLE;
         memcode_data_q  <= '0;
         host_rd_valid_q <= 1'b0;
         host_d4rd_q     <= '0;
      end else begin
         state_q         <= state_d;
         memcode_data_q  <= memcode_data_d;
         host_rd_valid_q <= host_grant && !bus.host_wr;
         if (host_rd_valid_q) begin
            host_d4rd_q <= bus.mem_rdata;
         end
      end
   end

   // Only one grant can be active, so the SRAM port never sees two users.
   assign bus.mem_cs    = code_grant || host_grant;
   assign bus.mem_we    = host_wr_acc;
   assign bus.mem_addr  = code_grant ? bus.memcode_addr : bus.host_addr;
   assign bus.mem_wdata = bus.host_d4wr;

   assign bus.memcode_read_valid = (state_q == ST_RESP);
   assign bus.memcode_data       = memcode_data_q;
   assign bus.host_ready         = host_grant;
   assign bus.host_rd_valid      = host_rd_valid_q;
   // SRAM output is already registered; hold the last word once the read completes
   assign bus.host_d4rd          = host_rd_valid_q ? bus.mem_rdata : host_d4rd_q;

endmodule

// File: tb/tb_m_memcode_server.sv
module tb_m_memcode_server;

   logic clk;
   logic rst_b;
   int   tests;
   int   fails;

   m_memcode_server_if #(.ADDR_WIDTH(14), .DATA_WIDTH(32)) bus ();

   m_memcode_server #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   logic [31:0] sram [0:16383];

   always @(posedge clk) begin
      if (bus.mem_cs) begin
         if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata      <= sram[bus.mem_addr];
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic host_write(input logic [13:0] a, input logic [31:0] d);
      step();
      bus.host_cs = 1'b1; bus.host_wr = 1'b1; bus.host_addr = a; bus.host_d4wr = d;
      step();
      bus.host_cs = 1'b0; bus.host_wr = 1'b0;
   endtask

   task automatic test_reset();
      rst_b = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++; if (bus.memcode_read_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", bus.memcode_read_valid); end
      tests++; if (bus.memcode_data !== 32'h0) begin fails++; $display("FAIL rst_data got %h exp 0", bus.memcode_data); end
      tests++; if (bus.host_rd_valid !== 1'b0) begin fails++; $display("FAIL rst_hrv got %b exp 0", bus.host_rd_valid); end
      tests++; if (bus.host_d4rd !== 32'h0) begin fails++; $display("FAIL rst_hd4rd got %h exp 0", bus.host_d4rd); end
      tests++; if (bus.mem_cs !== 1'b0 || bus.mem_we !== 1'b0) begin fails++; $display("FAIL rst_mem got cs=%b we=%b exp 0/0", bus.mem_cs, bus.mem_we); end
      rst_b = 1'b1;
   endtask

   task automatic test_basic_fetch();
      host_write(14'h0010, 32'hA5A5_0001);
      step();
      bus.memcode_rd = 1'b1; bus.memcode_addr = 14'h0010;
      @(negedge clk);
      tests++; if (bus.mem_cs !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 14'h0010) begin fails++; $display("FAIL basic_issue got cs=%b we=%b addr=%h exp 1/0/0010", bus.mem_cs, bus.mem_we, bus.mem_addr); end
      step(); @(negedge clk);
      tests++; if (bus.memcode_read_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %b exp 0", bus.memcode_read_valid); end
      step(); @(negedge clk);
      tests++; if (bus.memcode_read_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b exp 1", bus.memcode_read_valid); end
      tests++; if (bus.memcode_data !== 32'hA5A5_0001) begin fails++; $display("FAIL basic_data got %h exp a5a50001", bus.memcode_data); end
      step(); bus.memcode_rd = 1'b0; @(negedge clk);
      tests++; if (bus.memcode_read_valid !== 1'b0) begin fails++; $display("FAIL basic_single_pulse got %b exp 0", bus.memcode_read_valid); end
   endtask

   task automatic test_back_to_back();
      int  c, n, last;
      bit  got;
      for (int i = 0; i < 4; i++) host_write(14'(i), 32'hB0B0_0000 + 32'(i));
      step();
      bus.memcode_rd = 1'b1; bus.memcode_addr = 14'h0;
      c = 0; n = 0; last = 0;
      while (c < 40 && n < 4) begin
         @(negedge clk);
         got = bus.memcode_read_valid;
         if (got) begin
            tests++; if (bus.memcode_data !== 32'hB0B0_0000 + 32'(n)) begin fails++; $display("FAIL b2b_data%0d got %h exp %h", n, bus.memcode_data, 32'hB0B0_0000 + 32'(n)); end
            tests++; if ((n == 0 && c != 2) || (n > 0 && c - last != 3)) begin fails++; $display("FAIL b2b_spacing%0d got cycle %0d exp %0d", n, c, (n == 0) ? 2 : last + 3); end
            last = c; n++;
         end
         step();
         if (got) begin
            if (n < 4) bus.memcode_addr = 14'(n);
            else       bus.memcode_rd = 1'b0;
         end
         c++;
      end
      bus.memcode_rd = 1'b0;
      tests++; if (n != 4) begin fails++; $display("FAIL b2b_count got %0d exp 4", n); end
   endtask

   task automatic test_starvation();
      host_write(14'h0020, 32'h2020_2020);
      step();
      bus.host_cs = 1'b1; bus.host_wr = 1'b0; bus.host_addr = 14'h0100;
      bus.memcode_rd = 1'b1; bus.memcode_addr = 14'h0020;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         tests++; if (bus.host_ready !== ((k == 5) ? 1'b0 : 1'b1)) begin fails++; $display("FAIL starve_ready_c%0d got %b exp %b", k, bus.host_ready, (k == 5) ? 1'b0 : 1'b1); end
         if (k == 5) begin
            tests++; if (bus.mem_addr !== 14'h0020 || bus.mem_we !== 1'b0) begin fails++; $display("FAIL starve_issue got addr=%h we=%b exp 0020/0", bus.mem_addr, bus.mem_we); end
         end
         if (k == 7) begin
            tests++; if (bus.memcode_read_valid !== 1'b1 || bus.memcode_data !== 32'h2020_2020) begin fails++; $display("FAIL starve_fetch got v=%b d=%h exp 1/20202020", bus.memcode_read_valid, bus.memcode_data); end
         end
         step();
      end
      bus.host_cs = 1'b0; bus.memcode_rd = 1'b0;
   endtask

   task automatic test_host_read_in_wait();
      step();
      bus.memcode_rd = 1'b1; bus.memcode_addr = 14'h0002;
      step();
      bus.host_cs = 1'b1; bus.host_wr = 1'b0; bus.host_addr = 14'h0010;
      @(negedge clk);
      tests++; if (bus.host_ready !== 1'b1 || bus.mem_cs !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 14'h0010) begin fails++; $display("FAIL hrd_accept got rdy=%b cs=%b we=%b addr=%h exp 1/1/0/0010", bus.host_ready, bus.mem_cs, bus.mem_we, bus.mem_addr); end
      step();
      bus.host_cs = 1'b0;
      @(negedge clk);
      tests++; if (bus.host_rd_valid !== 1'b1 || bus.host_d4rd !== 32'hA5A5_0001) begin fails++; $display("FAIL hrd_data got v=%b d=%h exp 1/a5a50001", bus.host_rd_valid, bus.host_d4rd); end
      tests++; if (bus.memcode_read_valid !== 1'b1 || bus.memcode_data !== 32'hB0B0_0002) begin fails++; $display("FAIL hrd_code got v=%b d=%h exp 1/b0b00002", bus.memcode_read_valid, bus.memcode_data); end
      step();
      bus.memcode_rd = 1'b0;
      @(negedge clk);
      tests++; if (bus.host_rd_valid !== 1'b0) begin fails++; $display("FAIL hrd_pulse got %b exp 0", bus.host_rd_valid); end
   endtask

   task automatic test_write_in_wait();
      step();
      bus.memcode_rd = 1'b1; bus.memcode_addr = 14'h0001;
      step();
      bus.host_cs = 1'b1; bus.host_wr = 1'b1; bus.host_addr = 14'h0001; bus.host_d4wr = 32'h1111_1111;
      step();
      bus.host_cs = 1'b0; bus.host_wr = 1'b0;
      @(negedge clk);
      tests++; if (bus.memcode_read_valid !== 1'b1 || bus.memcode_data !== 32'hB0B0_0001) begin fails++; $display("FAIL wrwait_old got v=%b d=%h exp 1/b0b00001", bus.memcode_read_valid, bus.memcode_data); end
      step(); bus.memcode_rd = 1'b0;
      step(); bus.memcode_rd = 1'b1;
      @(negedge clk);
      tests++; if (bus.mem_cs !== 1'b1) begin fails++; $display("FAIL wrwait_refetch_sram got cs=%b exp 1", bus.mem_cs); end
      step(); step(); @(negedge clk);
      tests++; if (bus.memcode_read_valid !== 1'b1 || bus.memcode_data !== 32'h1111_1111) begin fails++; $display("FAIL wrwait_new got v=%b d=%h exp 1/11111111", bus.memcode_read_valid, bus.memcode_data); end
      step(); bus.memcode_rd = 1'b0;
   endtask

`ifdef MEMCODE_CACHE_EN
   task automatic test_cache();
      step();
      bus.memcode_rd = 1'b1; bus.memcode_addr = 14'h0010;
      step(); step(); @(negedge clk);
      tests++; if (bus.memcode_read_valid !== 1'b1 || bus.memcode_data !== 32'hA5A5_0001) begin fails++; $display("FAIL cache_fill got v=%b d=%h exp 1/a5a50001", bus.memcode_read_valid, bus.memcode_data); end
      step(); bus.memcode_rd = 1'b0;
      step(); bus.memcode_rd = 1'b1;
      @(negedge clk);
      tests++; if (bus.mem_cs !== 1'b0) begin fails++; $display("FAIL cache_hit_cs got %b exp 0", bus.mem_cs); end
      step(); @(negedge clk);
      tests++; if (bus.memcode_read_valid !== 1'b1 || bus.memcode_data !== 32'hA5A5_0001) begin fails++; $display("FAIL cache_hit got v=%b d=%h exp 1/a5a50001", bus.memcode_read_valid, bus.memcode_data); end
      step(); bus.memcode_rd = 1'b0;
      host_write(14'h0010, 32'hBEEF_0010);
      step(); bus.memcode_rd = 1'b1;
      @(negedge clk);
      tests++; if (bus.mem_cs !== 1'b1) begin fails++; $display("FAIL cache_inval_cs got %b exp 1", bus.mem_cs); end
      step(); step(); @(negedge clk);
      tests++; if (bus.memcode_read_valid !== 1'b1 || bus.memcode_data !== 32'hBEEF_0010) begin fails++; $display("FAIL cache_inval_data got v=%b d=%h exp 1/beef0010", bus.memcode_read_valid, bus.memcode_data); end
      step(); bus.memcode_rd = 1'b0;
   endtask
`endif

   task automatic test_rd_drop();
      step();
      bus.memcode_rd = 1'b1; bus.memcode_addr = 14'h0000;
      step();
      bus.memcode_rd = 1'b0;
      @(negedge clk);
      tests++; if (bus.memcode_read_valid !== 1'b0) begin fails++; $display("FAIL drop_early got %b exp 0", bus.memcode_read_valid); end
      step(); @(negedge clk);
      tests++; if (bus.memcode_read_valid !== 1'b1 || bus.memcode_data !== 32'hB0B0_0000) begin fails++; $display("FAIL drop_complete got v=%b d=%h exp 1/b0b00000", bus.memcode_read_valid, bus.memcode_data); end
   endtask

   task automatic test_reset_mid();
      host_write(14'h0005, 32'h5555_0005);
      step();
      bus.memcode_rd = 1'b1; bus.memcode_addr = 14'h0005;
      step();
      rst_b = 1'b0; bus.memcode_rd = 1'b0;
      #1;
      tests++; if (bus.memcode_read_valid !== 1'b0 || bus.memcode_data !== 32'h0) begin fails++; $display("FAIL rstmid_code got v=%b d=%h exp 0/0", bus.memcode_read_valid, bus.memcode_data); end
      tests++; if (bus.host_d4rd !== 32'h0 || bus.mem_cs !== 1'b0) begin fails++; $display("FAIL rstmid_host got d=%h cs=%b exp 0/0", bus.host_d4rd, bus.mem_cs); end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_b = 1'b1;
      step(); @(negedge clk);
      tests++; if (bus.memcode_read_valid !== 1'b0) begin fails++; $display("FAIL rstmid_stale got %b exp 0", bus.memcode_read_valid); end
      step();
      bus.memcode_rd = 1'b1; bus.memcode_addr = 14'h0005;
      @(negedge clk);
      tests++; if (bus.mem_cs !== 1'b1 || bus.memcode_read_valid !== 1'b0) begin fails++; $display("FAIL rstmid_issue got cs=%b v=%b exp 1/0", bus.mem_cs, bus.memcode_read_valid); end
      step(); step(); @(negedge clk);
      tests++; if (bus.memcode_read_valid !== 1'b1 || bus.memcode_data !== 32'h5555_0005) begin fails++; $display("FAIL rstmid_fetch got v=%b d=%h exp 1/55550005", bus.memcode_read_valid, bus.memcode_data); end
      step(); bus.memcode_rd = 1'b0;
   endtask

   initial begin
      tests = 0; fails = 0;
      for (int i = 0; i < 16384; i++) sram[i] = 32'h0;
      bus.mem_rdata    = 32'h0;
      bus.memcode_rd   = 1'b0; bus.memcode_addr = '0;
      bus.host_cs      = 1'b0; bus.host_wr = 1'b0;
      bus.host_addr    = '0;   bus.host_d4wr = '0;
      rst_b            = 1'b0;
      test_reset();
      test_basic_fetch();
      test_back_to_back();
      test_starvation();
      test_host_read_in_wait();
      test_write_in_wait();
`ifdef MEMCODE_CACHE_EN
      test_cache();
`endif
      test_rd_drop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
